// File: rtl/ahb_slave_mem_if_pkg.sv
// Shared AHB-Lite encodings used by the slave memory interface and its helpers.
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_type;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic is_active(input htrans_type t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if_be_gen.sv
// Alignment check and byte-lane enable generation for one AHB address phase.
module ahb_slave_be_gen
    import AHB_package::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] be,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        be      = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                be      = 4'b1111;
                illegal = |addr_lo;
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave bridging single transfers onto a synchronous word-wide memory port,
// with a programmable number of wait states and a two-cycle ERROR response.
module ahb_slave_mem_if
    import AHB_package::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_STATES    = 1
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata,
    input  logic                      hready_in,
    output logic                      hready_out,
    output hresp_type                 hresp,
    output logic [AHB_DATA_WIDTH-1:0] hrdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]                mem_be,
    output logic [AHB_DATA_WIDTH-1:0] mem_wdata,
    input  logic [AHB_DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] WR_CNT = 4'(WAIT_STATES);
    // Reads always need one cycle for the memory to return data.
    localparam logic [3:0] RD_CNT = (WAIT_STATES == 0) ? 4'd1 : 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

    state_t                    state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]                be_q;
    logic                      write_q;
    logic                      rd_first_q;

    logic                      addr_phase;
    logic                      accept;
    logic                      illegal;
    logic [3:0]                be_in;
    logic                      addr_hi_unused;

    assign addr_phase     = hsel & hready_in & is_active(htrans);
    assign addr_hi_unused = ^haddr[AHB_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    ahb_slave_be_gen u_be_gen (
        .addr_lo (haddr[1:0]),
        .size    (hsize),
        .be      (be_in),
        .illegal (illegal)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: accept = addr_phase;
            WAIT: begin
                hready_out = 1'b0;
                mem_req    = rd_first_q;
                cnt_nxt    = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = LAST;
            end
            LAST: begin
                accept    = addr_phase;
                state_nxt = IDLE;
                if (write_q) begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end else begin
                    hrdata = mem_rdata;
                end
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
                state_nxt  = ERR2;
            end
            ERR2: begin
                hresp     = HRESP_ERROR;
                accept    = addr_phase;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A new address phase overrides the return to IDLE for zero-bubble pipelining.
        if (accept) begin
            if (illegal) begin
                state_nxt = ERR1;
            end else begin
                cnt_nxt   = hwrite ? WR_CNT : RD_CNT;
                state_nxt = (cnt_nxt == 4'd0) ? LAST : WAIT;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = hwdata;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            write_q    <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rd_first_q <= accept & ~illegal & ~hwrite;
            if (accept) begin
                addr_q  <= haddr[MEM_ADDR_WIDTH+1:2];
                be_q    <= be_in;
                write_q <= hwrite;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem_if.sv
// Self-checking bench: two slaves (0 and 2 wait states) exercised by directed and random
// single transfers, checked against a byte-lane memory scoreboard.
module tb_ahb_slave_mem_if;
    import AHB_package::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_bus;
    int          sel;
    logic [1:0]  hsel;
    logic [31:0] haddr;
    htrans_type  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        hready_out [2];
    hresp_type   hresp      [2];
    logic [31:0] hrdata     [2];
    logic        mem_req    [2];
    logic        mem_we     [2];
    logic [9:0]  mem_addr   [2];
    logic [3:0]  mem_be     [2];
    logic [31:0] mem_wdata  [2];
    logic [31:0] mem_rdata  [2];

    logic [31:0] mem     [2][1024];
    logic [31:0] ref_mem [2][1024];
    logic        mem_clr;

    int vectors = 0;
    int miscompares = 0;

    always #5 hclk = ~hclk;

    assign hsel[0] = hsel_bus & (sel == 0);
    assign hsel[1] = hsel_bus & (sel == 1);

    ahb_slave_mem_if #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_out[0]),
        .hready_out(hready_out[0]), .hresp(hresp[0]), .hrdata(hrdata[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_be(mem_be[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    ahb_slave_mem_if #(.WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_out[1]),
        .hready_out(hready_out[1]), .hresp(hresp[1]), .hrdata(hrdata[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_be(mem_be[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Behavioural synchronous memory attached to each slave.
    always @(posedge hclk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                mem_rdata[k] <= '0;
                for (int w = 0; w < 1024; w++) mem[k][w] <= '0;
            end else if (mem_req[k]) begin
                if (mem_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b]) mem[k][mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
                end else begin
                    mem_rdata[k] <= mem[k][mem_addr[k]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete non-pipelined transfer; entered and left #1 after a rising edge.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
        int          waits;
        logic        bad;
        logic [3:0]  be;
        logic [9:0]  widx;
        logic [31:0] exp_rd;
        bad = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        if (wr)          waits = (k == 0) ? 0 : 2;
        else             waits = (k == 0) ? 1 : 2;
        if (size == 3'd0)      be = 4'b0001 << addr[1:0];
        else if (size == 3'd1) be = addr[1] ? 4'b1100 : 4'b0011;
        else                   be = 4'b1111;
        widx   = addr[11:2];
        exp_rd = ref_mem[k][widx];

        sel = k; hsel_bus = 1'b1; htrans = HTRANS_NONSEQ;
        haddr = addr; hwrite = wr; hsize = size;
        @(posedge hclk); #1;
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
        haddr = $urandom(); hwrite = ~wr; hsize = 3'($urandom_range(0, 7));

        if (bad) begin
            @(negedge hclk);
            check("err1_hready", 32'(hready_out[k]), 32'd0);
            check("err1_hresp",  32'(hresp[k]),      32'(HRESP_ERROR));
            check("err1_memreq", 32'(mem_req[k]),    32'd0);
            @(negedge hclk);
            check("err2_hready", 32'(hready_out[k]), 32'd1);
            check("err2_hresp",  32'(hresp[k]),      32'(HRESP_ERROR));
            check("err2_memreq", 32'(mem_req[k]),    32'd0);
        end else begin
            for (int c = 1; c <= waits; c++) begin
                @(negedge hclk);
                check("wait_hready", 32'(hready_out[k]), 32'd0);
                check("wait_hresp",  32'(hresp[k]),      32'(HRESP_OKAY));
                check("wait_hrdata", hrdata[k],          32'd0);
                check("wait_memreq", 32'(mem_req[k]),    32'(!wr && c == 1));
                if (!wr && c == 1) begin
                    check("rd_memwe",   32'(mem_we[k]),   32'd0);
                    check("rd_memaddr", 32'(mem_addr[k]), 32'(widx));
                end
            end
            @(negedge hclk);
            check("last_hready", 32'(hready_out[k]), 32'd1);
            check("last_hresp",  32'(hresp[k]),      32'(HRESP_OKAY));
            if (wr) begin
                check("wr_memreq",   32'(mem_req[k]),  32'd1);
                check("wr_memwe",    32'(mem_we[k]),   32'd1);
                check("wr_memaddr",  32'(mem_addr[k]), 32'(widx));
                check("wr_membe",    32'(mem_be[k]),   32'(be));
                check("wr_memwdata", mem_wdata[k],     wdata);
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[k][widx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                check("rd_last_memreq", 32'(mem_req[k]), 32'd0);
                check("rd_hrdata",      hrdata[k],       exp_rd);
            end
        end
        @(posedge hclk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  sz;
        int          k;

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 1024; w++) ref_mem[i][w] = '0;
        hreset = 1'b1; mem_clr = 1'b1; hsel_bus = 1'b0; sel = 0;
        htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0; mem_clr = 1'b0;

        // Reset state
        @(negedge hclk);
        for (int i = 0; i < 2; i++) begin
            check("rst_hready",  32'(hready_out[i]), 32'd1);
            check("rst_hresp",   32'(hresp[i]),      32'(HRESP_OKAY));
            check("rst_hrdata",  hrdata[i],          32'd0);
            check("rst_memreq",  32'(mem_req[i]),    32'd0);
            check("rst_memwe",   32'(mem_we[i]),     32'd0);
            check("rst_membe",   32'(mem_be[i]),     32'd0);
            check("rst_memaddr", 32'(mem_addr[i]),   32'd0);
        end
        @(posedge hclk); #1;

        // Word write then read at 0x10 with two wait states, misaligned halfword read
        xfer(1, 1'b1, 32'h0000_0010, HSIZE_WORD, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h0000_0010, HSIZE_WORD, 32'h0);
        check("ws2_rd_value", ref_mem[1][4], 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h0000_0013, HSIZE_HALF, 32'h0);

        // Selected slave seeing IDLE and BUSY answers zero-wait OKAY
        for (int t = 0; t < 2; t++) begin
            sel = 1; hsel_bus = 1'b1; htrans = (t == 0) ? HTRANS_IDLE : HTRANS_BUSY;
            haddr = 32'h0000_0010; hwrite = 1'b1; hsize = HSIZE_WORD;
            @(posedge hclk); #1;
            @(negedge hclk);
            check("idle_hready", 32'(hready_out[1]), 32'd1);
            check("idle_hresp",  32'(hresp[1]),      32'(HRESP_OKAY));
            check("idle_memreq", 32'(mem_req[1]),    32'd0);
            @(posedge hclk); #1;
        end
        hsel_bus = 1'b0; htrans = HTRANS_IDLE;

        // Back-to-back byte writes at 0x20 / 0x21 on the zero-wait slave
        sel = 0; hsel_bus = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_BYTE;
        haddr = 32'h0000_0020;
        @(posedge hclk); #1;
        haddr = 32'h0000_0021; htrans = HTRANS_SEQ; hwdata = 32'h0000_00A5;
        @(negedge hclk);
        check("b2b_hready0", 32'(hready_out[0]), 32'd1);
        check("b2b_memwe0",  32'(mem_we[0]),     32'd1);
        check("b2b_membe0",  32'(mem_be[0]),     32'h1);
        @(posedge hclk); #1;
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0000_5A00;
        @(negedge hclk);
        check("b2b_hready1", 32'(hready_out[0]), 32'd1);
        check("b2b_memwe1",  32'(mem_we[0]),     32'd1);
        check("b2b_membe1",  32'(mem_be[0]),     32'h2);
        @(posedge hclk); #1;
        ref_mem[0][8][7:0]  = 8'hA5;
        ref_mem[0][8][15:8] = 8'h5A;
        xfer(0, 1'b0, 32'h0000_0020, HSIZE_WORD, 32'h0);

        // Reset pulsed during the wait phase of a write abandons it
        sel = 1; hsel_bus = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        haddr = 32'h0000_0040;
        @(posedge hclk); #1;
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h1234_5678;
        @(negedge hclk);
        check("rstw_wait_hready", 32'(hready_out[1]), 32'd0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            check("rstw_hready", 32'(hready_out[1]), 32'd1);
            check("rstw_hresp",  32'(hresp[1]),      32'(HRESP_OKAY));
            check("rstw_memreq", 32'(mem_req[1]),    32'd0);
            check("rstw_memwe",  32'(mem_we[1]),     32'd0);
        end
        @(posedge hclk); #1;
        xfer(1, 1'b0, 32'h0000_0040, HSIZE_WORD, 32'h0);

        // Random single transfers, including wrapped upper address bits and bad sizes
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 1);
            r = $urandom();
            a = {r[31:12], 6'b000000, r[5:0]};
            if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(3, 7));
            else                           sz = 3'($urandom_range(0, 2));
            xfer(k, 1'($urandom_range(0, 1)), a, sz, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem_if.md
AHB_SLAVE_MEM_IF -- requirements
Module: ahb_slave_mem_if

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32: AHB address width.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32: AHB data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10: word-address width of the memory port.
REQ-004 SHALL have parameter WAIT_STATES, default 1: number of hready_out-low cycles per data phase, range 0..15.
REQ-005 SHALL have port hclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port hreset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port hsel, input, 1: slave select from the master-side decoder/arbiter.
REQ-008 SHALL have ports haddr (input, AHB_ADDR_WIDTH), htrans (input, htrans_type), hwrite (input, 1) and hsize (input, 3): address-phase control.
REQ-009 SHALL have port hwdata, input, 32: write data, valid in the data phase.
REQ-010 SHALL have port hready_in, input, 1: bus-wide HREADY.
REQ-011 SHALL have ports hready_out (output, 1), hresp (output, hresp_type) and hrdata (output, 32): the slave response.
REQ-012 SHALL have ports mem_req, mem_we (outputs, 1), mem_addr (output, MEM_ADDR_WIDTH), mem_be (output, 4) and mem_wdata (output, 32): the memory request.
REQ-013 SHALL have port mem_rdata, input, 32: read data, valid the cycle after a read mem_req and held until the next mem_req.

Function
REQ-014 SHALL accept an address phase only when hsel & hready_in & htrans is NONSEQ or SEQ, registering haddr, hwrite and hsize.
REQ-015 SHALL answer IDLE or BUSY with hsel high as zero-wait OKAY, with hready_out=1 and no mem_req.
REQ-016 SHALL flag an accepted transfer as illegal if hsize>2, or if a halfword has haddr[0]=1, or if a word has haddr[1:0]!=0.
REQ-017 SHALL use FSM states IDLE, WAIT, LAST, ERR1 and ERR2.
REQ-018 SHALL move from an illegal acceptance to ERR1 (hready_out=0, hresp=ERROR), then ERR2 (hready_out=1, hresp=ERROR), then IDLE, and SHALL issue no mem_req.
REQ-019 SHALL, on a legal acceptance, load a counter with the value cnt: for a read, max(WAIT_STATES,1); for a write, WAIT_STATES.
REQ-020 SHALL then enter LAST if cnt=0 and WAIT otherwise.
REQ-021 SHALL, in WAIT, drive hready_out=0 and hresp=OKAY, decrement cnt, and move to LAST when cnt reaches 1.
REQ-022 SHALL, in LAST, drive hready_out=1 and hresp=OKAY.
REQ-023 SHALL, for a read, pulse mem_req=1, mem_we=0 in the first data-phase cycle, and drive hrdata=mem_rdata in LAST only (0 otherwise).
REQ-024 SHALL, for a write, assert mem_req=1 and mem_we=1 in LAST, with mem_wdata=hwdata.
REQ-025 SHALL drive mem_addr = registered haddr[MEM_ADDR_WIDTH+1:2], ignoring upper bits (out-of-range addresses wrap).
REQ-026 SHALL drive mem_be as follows: byte, 1<<haddr[1:0]; halfword, 3<<(2*haddr[1]); word, 4'hF.
REQ-027 SHALL, in LAST and in ERR2, accept a new address phase in the same cycle so back-to-back transfers run without a bubble; otherwise it returns to IDLE.
REQ-028 SHALL ignore address phases during WAIT and ERR1.
REQ-029 SHALL give a transfer accepted while WAIT_STATES=0 a single-cycle write phase and a two-cycle read phase.

Reset
REQ-030 SHALL, with hreset high at a clock edge, enter IDLE, clear cnt and all captured registers, and drive hready_out=1, hresp=OKAY, hrdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0.
REQ-031 SHALL treat reset asserted mid-transfer (WAIT, LAST, ERR1 or ERR2) as abandoning the transfer: no mem_req in any cycle after the reset edge.

Structure
REQ-032 SHALL take htrans_type (IDLE/BUSY/NONSEQ/SEQ), hresp_type (OKAY/ERROR) and the hsize encodings from AHB_package; the FSM state enum stays local.
REQ-033 SHALL place the alignment check and byte-enable generation in one combinational sub-module, ahb_slave_be_gen.

Verification
REQ-034 SHALL cover, with WAIT_STATES=2, a word write at 0x0000_0010 of 0xDEADBEEF -> hready_out low 2 cycles, then high; in that cycle mem_we=1, mem_addr=4, mem_be=4'hF, mem_wdata=0xDEADBEEF.
REQ-035 SHALL cover, with WAIT_STATES=2, a word read at 0x0000_0010 -> mem_req in data cycle 1, hready_out high in cycle 3, hrdata=0xDEADBEEF, hresp=OKAY.
REQ-036 SHALL cover a halfword read at 0x0000_0013 -> ERR1 (hready_out=0, ERROR) then ERR2 (hready_out=1, ERROR), and no mem_req.
REQ-037 SHALL cover, with WAIT_STATES=0, back-to-back byte writes at 0x20 then 0x21 -> mem_be 4'b0001 then 4'b0010 on consecutive cycles, with hready_out held at 1.
REQ-038 SHALL cover hsel=1 with htrans=IDLE -> hready_out=1, OKAY, mem_req=0.
REQ-039 SHALL cover hreset pulsed during WAIT of a write -> next cycle IDLE, hready_out=1, OKAY, and mem_we never asserted.
